// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - state encodings and control-word types for pipeline_ctrl
package pipeline_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Encoding 2'd3 is unused and treated as HALT so a corrupted state stays safe.
    function automatic logic is_halt(input logic [1:0] st);
        return st[1];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_use_stall,
    input  logic             i_branch_taken,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_ex_en,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_halted,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_mem_err;
    logic              w_mem_err_nxt;
    logic              w_is_run;
    logic              w_is_wait;
    logic              w_is_halt;
    logic              w_timeout;
    logic              w_freeze;
    ctrl_t             w_ctrl;

    assign w_is_run  = (r_state == ST_RUN);
    assign w_is_wait = (r_state == ST_MEM_WAIT);
    assign w_is_halt = is_halt(r_state);
    assign w_timeout = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    assign w_freeze = w_is_halt
                    | (w_is_wait & ~i_dmem_ready)
                    | (w_is_run & i_dmem_req & ~i_dmem_ready)
                    | (w_is_run & i_halt_req);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_mem_err_nxt = r_mem_err;
        case (r_state)
            ST_RUN: begin
                if (i_dmem_req && !i_dmem_ready) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else if (i_halt_req) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                if (i_dmem_ready) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end else if (w_timeout) begin
                    w_state_nxt   = ST_HALT;
                    w_wait_nxt    = '0;
                    w_mem_err_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                // A memory timeout is fatal: only reset leaves HALT after mem_err.
                if (i_resume && !r_mem_err) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    // A same-cycle load-use under a branch is a wrong-path instruction.
    always_comb begin
        w_ctrl = CTRL_NORMAL;
        if (!i_rst_n || w_freeze) begin
            w_ctrl = CTRL_FROZEN;
        end else if (i_branch_taken) begin
            w_ctrl = CTRL_BRANCH;
        end else if (i_load_use_stall) begin
            w_ctrl = CTRL_LOAD_USE;
        end
    end

    assign o_pc_en       = w_ctrl.pc_en;
    assign o_if_id_en    = w_ctrl.if_id_en;
    assign o_id_ex_en    = w_ctrl.id_ex_en;
    assign o_ex_mem_en   = w_ctrl.ex_mem_en;
    assign o_mem_wb_en   = w_ctrl.mem_wb_en;
    assign o_if_id_flush = w_ctrl.if_id_flush;
    assign o_id_ex_flush = w_ctrl.id_ex_flush;
    assign o_halted      = w_is_halt;
    assign o_mem_err     = r_mem_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (~w_ctrl.pc_en),
        .o_count (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_ctrl.if_id_flush),
        .o_count (o_flush_events)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl (16-bit and 4-bit counter instances)
module tb_pipeline_ctrl;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lu = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0, hq = 1'b0, rs = 1'b0;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, halted, mem_err;
    logic [15:0] stall_cycles, flush_events;
    logic pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4, halted4, mem_err4;
    logic [3:0] stall_cycles4, flush_events4;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      name;
        logic [4:0] en;
        logic [1:0] fl;
        logic       h;
        logic       e;
        logic       chk;
        int         s;
        int         f;
    } exp_t;

    exp_t q[$];
    exp_t x;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_use_stall(lu), .i_branch_taken(br),
        .i_dmem_req(req), .i_dmem_ready(rdy), .i_halt_req(hq), .i_resume(rs),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
        .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
        .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_halted(halted), .o_mem_err(mem_err),
        .o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_use_stall(lu), .i_branch_taken(br),
        .i_dmem_req(req), .i_dmem_ready(rdy), .i_halt_req(hq), .i_resume(rs),
        .o_pc_en(pc_en4), .o_if_id_en(if_id_en4), .o_id_ex_en(id_ex_en4),
        .o_ex_mem_en(ex_mem_en4), .o_mem_wb_en(mem_wb_en4),
        .o_if_id_flush(if_id_flush4), .o_id_ex_flush(id_ex_flush4),
        .o_halted(halted4), .o_mem_err(mem_err4),
        .o_stall_cycles(stall_cycles4), .o_flush_events(flush_events4)
    );

    function automatic void cmp(input string nm, input int act, input int req_v);
        total++;
        if (act != req_v) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, act, req_v);
        end
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            x = q.pop_front();
            cmp({x.name, ".en"}, int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), int'(x.en));
            cmp({x.name, ".flush"}, int'({if_id_flush, id_ex_flush}), int'(x.fl));
            cmp({x.name, ".halted"}, int'(halted), int'(x.h));
            cmp({x.name, ".mem_err"}, int'(mem_err), int'(x.e));
            cmp({x.name, ".en4"}, int'({pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4, halted4, mem_err4}),
                int'({x.en, x.fl, x.h, x.e}));
            if (x.chk) begin
                cmp({x.name, ".stall_cycles"}, int'(stall_cycles), x.s);
                cmp({x.name, ".flush_events"}, int'(flush_events), x.f);
                cmp({x.name, ".stall_cycles4"}, int'(stall_cycles4), sat4(x.s));
                cmp({x.name, ".flush_events4"}, int'(flush_events4), sat4(x.f));
            end
        end
    end

    task automatic step(input string nm, input logic i_rst, input logic i_lu, input logic i_br,
                        input logic i_req, input logic i_rdy, input logic i_hq, input logic i_rs,
                        input logic [4:0] en, input logic [1:0] fl, input logic h, input logic e,
                        input logic chk, input int s, input int f);
        exp_t t;
        @(posedge clk);
        #1;
        rst_n = i_rst; lu = i_lu; br = i_br; req = i_req; rdy = i_rdy; hq = i_hq; rs = i_rs;
        t.name = nm; t.en = en; t.fl = fl; t.h = h; t.e = e; t.chk = chk; t.s = s; t.f = f;
        q.push_back(t);
    endtask

    initial begin
        //    name         rst lu br rq rd hq rs  en       fl     h  e  chk s  f
        step("rst",        0, 0, 0, 0, 0, 0, 0, EN_NONE, 2'b00, 0, 0, 1, 0, 0);
        step("rst2",       0, 0, 0, 0, 0, 0, 0, EN_NONE, 2'b00, 0, 0, 0, 0, 0);
        step("idle",       1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 0, 0);
        step("idle2",      1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 0, 0);
        step("lu",         1, 1, 0, 0, 0, 0, 0, EN_LU,   2'b01, 0, 0, 0, 0, 0);
        step("after_lu",   1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 1, 0);
        step("br_lu",      1, 1, 1, 0, 0, 0, 0, EN_ALL,  2'b11, 0, 0, 0, 0, 0);
        step("after_br",   1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 1, 1);
        step("mw0",        1, 0, 0, 1, 0, 0, 0, EN_NONE, 2'b00, 0, 0, 0, 0, 0);
        step("mw1_br",     1, 0, 1, 1, 0, 0, 0, EN_NONE, 2'b00, 0, 0, 0, 0, 0);
        step("mw2",        1, 0, 0, 1, 0, 0, 0, EN_NONE, 2'b00, 0, 0, 0, 0, 0);
        step("mw_rdy",     1, 0, 0, 1, 1, 0, 0, EN_ALL,  2'b00, 0, 0, 0, 0, 0);
        step("after_mw",   1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 4, 1);
        step("zero_wait",  1, 0, 0, 1, 1, 0, 0, EN_ALL,  2'b00, 0, 0, 0, 0, 0);
        step("after_zw",   1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 4, 1);
        step("halt_req",   1, 0, 0, 0, 0, 1, 0, EN_NONE, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("halted",     1, 0, 0, 0, 0, (i == 2), 0, EN_NONE, 2'b00, 1, 0, 0, 0, 0);
        step("resume",     1, 0, 0, 0, 0, 0, 1, EN_NONE, 2'b00, 1, 0, 0, 0, 0);
        step("after_res",  1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 11, 1);
        for (int i = 0; i < 10; i++)
            step("lu_sat",     1, 1, 0, 0, 0, 0, 0, EN_LU,   2'b01, 0, 0, 0, 0, 0);
        step("after_sat",  1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 21, 1);
        for (int i = 0; i < 16; i++)
            step("timeout",    1, 0, 0, 1, 0, 0, 0, EN_NONE, 2'b00, 0, 0, 0, 0, 0);
        step("to_halt",    1, 0, 0, 1, 0, 0, 0, EN_NONE, 2'b00, 1, 1, 0, 0, 0);
        step("to_resume",  1, 0, 0, 0, 0, 0, 1, EN_NONE, 2'b00, 1, 1, 0, 0, 0);
        step("to_stuck",   1, 0, 0, 0, 0, 0, 0, EN_NONE, 2'b00, 1, 1, 1, 39, 1);
        step("rst_mid",    0, 0, 0, 0, 0, 0, 0, EN_NONE, 2'b00, 0, 0, 1, 0, 0);
        step("rst_rel",    1, 0, 0, 0, 0, 0, 0, EN_ALL,  2'b00, 0, 0, 1, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d expected=0 pending entries", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
